// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, grant encoding and fetch address helper for the instruction RAM arbiter
package imem_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_FETCH, GRANT_LOAD} grant_t;
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr >> 2) < depth;
  endfunction
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and RAM bus signals around the instruction RAM arbiter
interface imem_arbiter_if #(parameter int ADDR_W = 3);
  logic fetch_req;
  logic [31:0] fetch_addr;
  logic fetch_gnt;
  logic fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic fetch_err;
  logic ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0] ld_wdata;
  logic ld_gnt;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    input fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp: one-cycle fetch response stage returning RAM data or an error NOP
module imem_fetch_resp import imem_pkg::*; #(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_issue,
  input  logic        err_issue,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic        err,
  output logic [31:0] rdata
);
  logic rd_pending, err_pending;
  // remember what kind of fetch was accepted last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending  <= 1'b0;
      err_pending <= 1'b0;
    end else begin
      rd_pending  <= rd_issue;
      err_pending <= err_issue;
    end
  end
  // reset drops an in-flight response immediately
  assign rvalid = (rd_pending | err_pending) & ~rst;
  assign err    = err_pending & ~rst;
  assign rdata  = rst ? 32'h0 : rd_pending ? mem_rdata : err_pending ? NOP_WORD : 32'h0;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port instruction RAM between CPU fetch and the program loader
module imem_arbiter import imem_pkg::*; #(
  parameter int          FW_LENGTH  = 8,
  parameter int          ADDR_W     = $clog2(FW_LENGTH),
  parameter int          MAX_STREAK = 4,
  parameter logic [31:0] NOP_INSTR  = imem_pkg::NOP_INSTR
) (
  input logic clk,
  input logic rst,
  imem_arbiter_if.slave bus
);
  logic       bad, force_fetch, rd_go;
  logic [3:0] streak;
  grant_t     grant;
  assign bad = (bus.fetch_addr[1:0] != 2'b00) || !word_in_range(bus.fetch_addr, FW_LENGTH);
  assign force_fetch = bus.fetch_req && streak == 4'(MAX_STREAK);
  // loader wins unless a waiting fetch has been starved for MAX_STREAK grants
  always_comb grant = rst ? GRANT_NONE : (bus.ld_req && !force_fetch) ? GRANT_LOAD : bus.fetch_req ? GRANT_FETCH : GRANT_NONE;
  assign bus.fetch_gnt = grant == GRANT_FETCH;
  assign bus.ld_gnt    = grant == GRANT_LOAD;
  assign rd_go         = bus.fetch_gnt && !bad;
  assign bus.mem_en    = bus.ld_gnt || rd_go;
  assign bus.mem_we    = bus.ld_gnt;
  assign bus.mem_addr  = bus.ld_gnt ? bus.ld_addr : rd_go ? bus.fetch_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata = bus.ld_gnt ? bus.ld_wdata : 32'h0;
  // count loader grants taken while a fetch waits
  always_ff @(posedge clk) begin
    if (rst || !bus.fetch_req || bus.fetch_gnt) streak <= '0;
    else if (bus.ld_gnt && streak != 4'(MAX_STREAK)) streak <= streak + 4'd1;
  end
  imem_fetch_resp #(.NOP_WORD(NOP_INSTR)) u_resp (
    .clk       (clk),
    .rst       (rst),
    .rd_issue  (rd_go),
    .err_issue (bus.fetch_gnt && bad),
    .mem_rdata (bus.mem_rdata),
    .rvalid    (bus.fetch_rvalid),
    .err       (bus.fetch_err),
    .rdata     (bus.fetch_rdata)
  );
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random checks of the instruction RAM arbiter against a behavioural RAM
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ram [8];
  imem_arbiter_if #(.ADDR_W(3)) bus();
  imem_arbiter #(.FW_LENGTH(8), .MAX_STREAK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end
  task automatic set(input logic fr, input logic [31:0] fa, input logic lr, input logic [2:0] la, input logic [31:0] lw);
    bus.fetch_req = fr;
    bus.fetch_addr = fa;
    bus.ld_req = lr;
    bus.ld_addr = la;
    bus.ld_wdata = lw;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    set(1, 0, 1, 0, 32'h1);
    tick();
    set(1, 0, 1, 0, 32'h1);
    n_cmp++; if (bus.fetch_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_fetch_gnt got %b exp 0", bus.fetch_gnt); end
    n_cmp++; if (bus.ld_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_ld_gnt got %b exp 0", bus.ld_gnt); end
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %b exp 0", bus.mem_en); end
    n_cmp++; if (bus.fetch_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %b exp 0", bus.fetch_rvalid); end
    n_cmp++; if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", bus.fetch_err); end
    n_cmp++; if (bus.fetch_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h exp 00000000", bus.fetch_rdata); end
    tick();
    rst = 1'b0;
    set(0, 0, 0, 0, 0);
    tick();
  endtask
  task automatic test_seq_fetch();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA000_0000;
    exp_d[1] = 32'hA000_0001;
    exp_d[2] = 32'hA000_0002;
    for (int i = 0; i < 5; i++) begin
      set(i < 3, 32'(i * 4), 0, 0, 0);
      if (i < 3) begin
        n_cmp++; if (bus.fetch_gnt !== 1'b1) begin n_bad++; $display("FAIL seq_gnt[%0d] got %b exp 1", i, bus.fetch_gnt); end
        n_cmp++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 3'(i)) begin n_bad++; $display("FAIL seq_mem[%0d] got en=%b we=%b addr=%0d exp en=1 we=0 addr=%0d", i, bus.mem_en, bus.mem_we, bus.mem_addr, i); end
      end
      if (i > 0 && i < 4) begin
        n_cmp++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL seq_rvalid[%0d] got v=%b e=%b exp v=1 e=0", i, bus.fetch_rvalid, bus.fetch_err); end
        n_cmp++; if (bus.fetch_rdata !== exp_d[i-1]) begin n_bad++; $display("FAIL seq_rdata[%0d] got %h exp %h", i, bus.fetch_rdata, exp_d[i-1]); end
      end
      if (i == 4) begin
        n_cmp++; if (bus.fetch_rvalid !== 1'b0) begin n_bad++; $display("FAIL seq_idle_rvalid got %b exp 0", bus.fetch_rvalid); end
      end
      tick();
    end
  endtask
  task automatic test_bad_fetch();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0000_0002;
    addrs[1] = 32'h0000_0020;
    addrs[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      set(1, addrs[i], 0, 0, 0);
      n_cmp++; if (bus.fetch_gnt !== 1'b1) begin n_bad++; $display("FAIL bad_gnt[%h] got %b exp 1", addrs[i], bus.fetch_gnt); end
      n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL bad_mem_en[%h] got %b exp 0", addrs[i], bus.mem_en); end
      tick();
      set(0, 0, 0, 0, 0);
      n_cmp++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_err !== 1'b1) begin n_bad++; $display("FAIL bad_resp[%h] got v=%b e=%b exp v=1 e=1", addrs[i], bus.fetch_rvalid, bus.fetch_err); end
      n_cmp++; if (bus.fetch_rdata !== 32'h0000_0013) begin n_bad++; $display("FAIL bad_rdata[%h] got %h exp 00000013", addrs[i], bus.fetch_rdata); end
      tick();
    end
  endtask
  task automatic test_streak();
    for (int i = 0; i < 6; i++) begin
      set(1, 32'h0, 1, 5, 32'h5555_0000 + 32'(i));
      n_cmp++; if (bus.ld_gnt !== (i != 4)) begin n_bad++; $display("FAIL streak_ld[%0d] got %b exp %b", i, bus.ld_gnt, i != 4); end
      n_cmp++; if (bus.fetch_gnt !== (i == 4)) begin n_bad++; $display("FAIL streak_fetch[%0d] got %b exp %b", i, bus.fetch_gnt, i == 4); end
      if (i == 5) begin
        n_cmp++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 32'hA000_0000) begin n_bad++; $display("FAIL streak_resp got v=%b d=%h exp v=1 d=a0000000", bus.fetch_rvalid, bus.fetch_rdata); end
      end
      tick();
    end
    set(0, 0, 0, 0, 0);
    tick();
  endtask
  task automatic test_write_read();
    set(0, 0, 1, 3, 32'hDEAD_BEEF);
    n_cmp++; if (bus.ld_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_ctrl got g=%b en=%b we=%b exp 1 1 1", bus.ld_gnt, bus.mem_en, bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 3'd3 || bus.mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_bus got a=%0d d=%h exp a=3 d=deadbeef", bus.mem_addr, bus.mem_wdata); end
    tick();
    set(1, 32'd12, 0, 0, 0);
    n_cmp++; if (bus.fetch_gnt !== 1'b1) begin n_bad++; $display("FAIL wr_rd_gnt got %b exp 1", bus.fetch_gnt); end
    tick();
    set(0, 0, 0, 0, 0);
    n_cmp++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rd_data got v=%b d=%h exp v=1 d=deadbeef", bus.fetch_rvalid, bus.fetch_rdata); end
    tick();
  endtask
  task automatic test_reset_mid();
    set(1, 32'd4, 0, 0, 0);
    n_cmp++; if (bus.fetch_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_gnt got %b exp 1", bus.fetch_gnt); end
    tick();
    rst = 1'b1;
    set(0, 0, 0, 0, 0);
    n_cmp++; if (bus.fetch_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_rvalid_during got %b exp 0", bus.fetch_rvalid); end
    tick();
    rst = 1'b0;
    set(0, 0, 0, 0, 0);
    n_cmp++; if (bus.fetch_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_rvalid_after got %b exp 0", bus.fetch_rvalid); end
    for (int i = 0; i < 3; i++) begin
      set(1, 0, 1, 6, 32'(i));
      tick();
    end
    rst = 1'b1;
    set(1, 0, 1, 6, 32'h7);
    n_cmp++; if (bus.ld_gnt !== 1'b0 || bus.fetch_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rm_force got ld=%b f=%b en=%b exp 0 0 0", bus.ld_gnt, bus.fetch_gnt, bus.mem_en); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set(1, 0, 1, 6, 32'h8);
      n_cmp++; if (bus.ld_gnt !== (i < 4) || bus.fetch_gnt !== (i == 4)) begin n_bad++; $display("FAIL rm_streak[%0d] got ld=%b f=%b exp ld=%b f=%b", i, bus.ld_gnt, bus.fetch_gnt, i < 4, i == 4); end
      tick();
    end
    set(0, 0, 0, 0, 0);
    tick();
  endtask
  task automatic test_random();
    logic pend_f = 1'b0;
    logic pend_l = 1'b0;
    logic [31:0] fa = 32'h0;
    logic [2:0] la = 3'h0;
    logic [31:0] lw = 32'h0;
    logic prev_g = 1'b0;
    logic prev_bad = 1'b0;
    int n_fg = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!pend_f) begin
        pend_f = 1'($urandom_range(0, 1));
        fa = 32'($urandom_range(0, 47));
      end
      if (!pend_l) begin
        pend_l = 1'($urandom_range(0, 1));
        la = 3'($urandom_range(0, 7));
        lw = $urandom;
      end
      set(pend_f, fa, pend_l, la, lw);
      n_cmp++; if (bus.fetch_gnt === 1'b1 && bus.ld_gnt === 1'b1) begin n_bad++; $display("FAIL rnd_both[%0d] got both grants exp at most one", i); end
      n_cmp++; if (bus.fetch_rvalid !== prev_g) begin n_bad++; $display("FAIL rnd_rvalid[%0d] got %b exp %b", i, bus.fetch_rvalid, prev_g); end
      if (prev_g) begin
        n_cmp++; if (bus.fetch_err !== prev_bad) begin n_bad++; $display("FAIL rnd_err[%0d] got %b exp %b", i, bus.fetch_err, prev_bad); end
      end
      prev_g = bus.fetch_gnt;
      prev_bad = (fa[1:0] != 2'b00) || (fa >= 32'd32);
      if (bus.fetch_gnt === 1'b1) begin pend_f = 1'b0; n_fg++; end
      if (bus.ld_gnt === 1'b1) pend_l = 1'b0;
      tick();
    end
    set(0, 0, 0, 0, 0);
    n_cmp++; if (bus.fetch_rvalid !== prev_g) begin n_bad++; $display("FAIL rnd_last_rvalid got %b exp %b", bus.fetch_rvalid, prev_g); end
    n_cmp++; if (n_fg == 0) begin n_bad++; $display("FAIL rnd_progress got %0d fetch grants exp >0", n_fg); end
    tick();
  endtask
  initial begin
    for (int i = 0; i < 8; i++) ram[i] <= 32'hA000_0000 | 32'(i);
    set(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_seq_fetch();
    test_bad_fetch();
    test_streak();
    test_write_read();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
